// File: rtl/sym_dn_lut_pkg.sv
// ============================================================================
// Module   : sym_dn_lut_pkg
// Purpose  : Shared types and sizing for the symmetric decision-node LUT loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sym_dn_lut_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } loader_state_t;

  localparam int DEF_IN_W        = 16;
  localparam int DEF_PAGE_AW     = 6;
  localparam int PAGES           = 2**DEF_PAGE_AW;
  localparam int PAIRS_PER_WORD  = DEF_IN_W/2;
  localparam int WORDS_PER_TABLE = 2*PAGES/DEF_IN_W;

  // Index width that stays legal even for a single pair per word.
  function automatic int idx_width(input int pairs);
    return (pairs > 1) ? $clog2(pairs) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sym_dn_lut_loader_pair_shifter.sv
// ============================================================================
// Module   : lut_pair_shifter
// Purpose  : Word register that shifts out one bank0/bank1 bit pair per step.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lut_pair_shifter
  import sym_dn_lut_pkg::*;
#(
  parameter int IN_W = DEF_IN_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            shift,
  input  logic [IN_W-1:0] load_data,
  output logic [1:0]      next_pair,
  output logic            last_pair
);

  localparam int PAIRS = IN_W/2;
  localparam int IDX_W = idx_width(PAIRS);

  logic [IN_W-1:0]  r_sh;
  logic [IN_W-1:0]  w_shifted;
  logic [IDX_W-1:0] r_idx;

  assign w_shifted = r_sh >> 2;
  // Pair that sits in bits [1:0] after this edge, so callers can register it.
  assign next_pair = load ? load_data[1:0] : w_shifted[1:0];
  assign last_pair = (r_idx == IDX_W'(PAIRS-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh  <= '0;
      r_idx <= '0;
    end else if (load) begin
      r_sh  <= load_data;
      r_idx <= '0;
    end else if (shift && !last_pair) begin
      r_sh  <= w_shifted;
      r_idx <= r_idx + IDX_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/sym_dn_lut_loader.sv
// ============================================================================
// Module   : sym_dn_lut_loader
// Purpose  : Streams packed LUT words into one offset half of the LUT rank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sym_dn_lut_loader
  import sym_dn_lut_pkg::*;
#(
  parameter int IN_W    = DEF_IN_W,
  parameter int PAGE_AW = DEF_PAGE_AW
) (
  input  logic               write_clk,
  input  logic               rst,
  input  logic               start,
  input  logic               start_offset,
  input  logic               abort,
  input  logic               in_valid,
  input  logic [IN_W-1:0]    in_data,
  output logic               in_ready,
  output logic               lut_in_bank0,
  output logic               lut_in_bank1,
  output logic [PAGE_AW-1:0] page_write_addr,
  output logic               write_addr_offset,
  output logic               we,
  output logic               busy,
  output logic               done
);

  loader_state_t      r_state;
  logic [PAGE_AW:0]   r_cnt;
  logic               r_offset;
  logic               r_we;
  logic               r_b0;
  logic               r_b1;
  logic [PAGE_AW-1:0] r_page;

  logic       w_last_pair;
  logic       w_final;
  logic       w_accept;
  logic       w_shift;
  logic       w_issue;
  logic [1:0] w_next_pair;

  // r_cnt counts pages already issued; its MSB marks the wrap past the last page.
  assign w_final = r_cnt[PAGE_AW];

  always_comb begin
    in_ready = 1'b0;
    case (r_state)
      S_LOAD:  in_ready = ~abort;
      S_WRITE: in_ready = w_last_pair & ~w_final & ~abort;
      default: in_ready = 1'b0;
    endcase
  end

  assign w_accept = in_valid & in_ready;
  assign w_shift  = (r_state == S_WRITE) & ~w_last_pair;
  assign w_issue  = ((r_state == S_LOAD) & w_accept) |
                    ((r_state == S_WRITE) & ~abort & (~w_last_pair | w_accept));

  lut_pair_shifter #(
    .IN_W (IN_W)
  ) u_shifter (
    .clk       (write_clk),
    .rst       (rst),
    .load      (w_accept),
    .shift     (w_shift),
    .load_data (in_data),
    .next_pair (w_next_pair),
    .last_pair (w_last_pair)
  );

  always_ff @(posedge write_clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_offset <= 1'b0;
      r_we     <= 1'b0;
      r_b0     <= 1'b0;
      r_b1     <= 1'b0;
      r_page   <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_state  <= S_LOAD;
            r_offset <= start_offset;
            r_cnt    <= '0;
          end
        end
        S_LOAD: begin
          if (abort)         r_state <= S_IDLE;
          else if (w_accept) r_state <= S_WRITE;
        end
        S_WRITE: begin
          if (abort)                          r_state <= S_IDLE;
          else if (w_last_pair && !w_accept)  r_state <= w_final ? S_DONE : S_LOAD;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      // Outputs are loaded with the pair for the cycle that follows this edge.
      if (w_issue) begin
        r_we   <= 1'b1;
        r_b0   <= w_next_pair[0];
        r_b1   <= w_next_pair[1];
        r_page <= r_cnt[PAGE_AW-1:0];
        r_cnt  <= r_cnt + (PAGE_AW+1)'(1);
      end
    end
  end

  assign lut_in_bank0      = r_b0;
  assign lut_in_bank1      = r_b1;
  assign page_write_addr   = r_page;
  assign write_addr_offset = r_offset;
  assign we                = r_we;
  assign busy              = (r_state == S_LOAD) | (r_state == S_WRITE);
  assign done              = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_sym_dn_lut_loader.sv
// ============================================================================
// Module   : tb_sym_dn_lut_loader
// Purpose  : Directed self-checking bench for sym_dn_lut_loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sym_dn_lut_loader;

  localparam int NPAGES = 64;

  logic        write_clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start_offset = 1'b0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0;
  logic        in_ready, lut_in_bank0, lut_in_bank1, write_addr_offset, we, busy, done;
  logic [5:0]  page_write_addr;

  sym_dn_lut_loader #(.IN_W(16), .PAGE_AW(6)) dut (
    .write_clk         (write_clk),
    .rst               (rst),
    .start             (start),
    .start_offset      (start_offset),
    .abort             (abort),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_ready          (in_ready),
    .lut_in_bank0      (lut_in_bank0),
    .lut_in_bank1      (lut_in_bank1),
    .page_write_addr   (page_write_addr),
    .write_addr_offset (write_addr_offset),
    .we                (we),
    .busy              (busy),
    .done              (done)
  );

  always #5 write_clk = ~write_clk;

  int n_tests = 0;
  int n_fail  = 0;

  int   n_writes, order_err, off_err, ready_in_done, busy_at_done;
  int   done_gap_err, we_after_abort, busy_after_abort;
  bit   saw_done, timed_out, aborted;
  logic wr_b0 [NPAGES];
  logic wr_b1 [NPAGES];

  task automatic tick();
    @(posedge write_clk);
    #1;
  endtask

  // Runs one load and records what the write port did; checking is left to callers.
  task automatic run_load(input logic off, input logic [15:0] w0, input logic [15:0] wr,
                          input int period, input int abort_page, input int restart_at);
    int cyc = 0;
    int sent = 0;
    int last_we_cyc = -10;
    int post = -1;
    bit pend = 1'b0;
    n_writes = 0; order_err = 0; off_err = 0; ready_in_done = 0; busy_at_done = 0;
    done_gap_err = 0; we_after_abort = 0; busy_after_abort = 0;
    saw_done = 1'b0; timed_out = 1'b0; aborted = 1'b0;
    for (int i = 0; i < NPAGES; i++) begin wr_b0[i] = 1'bx; wr_b1[i] = 1'bx; end
    start = 1'b1; start_offset = off;
    tick();
    start = 1'b0;
    while (cyc < 3000) begin
      if (we) begin
        if (n_writes >= NPAGES || page_write_addr != n_writes[5:0]) order_err++;
        else begin wr_b0[n_writes] = lut_in_bank0; wr_b1[n_writes] = lut_in_bank1; end
        if (write_addr_offset !== off) off_err++;
        if (aborted) we_after_abort++;
        last_we_cyc = cyc;
        n_writes++;
      end
      if (done) begin
        saw_done = 1'b1;
        if (last_we_cyc != cyc - 1) done_gap_err++;
        if (busy) busy_at_done++;
        if (in_ready) ready_in_done++;
        if (post < 0) post = 2;
      end
      if (aborted && busy) busy_after_abort++;
      if (post == 0) break;
      if (post > 0) post--;
      abort = 1'b0; start = 1'b0; start_offset = 1'b0;
      if (abort_page >= 0 && !aborted && we && page_write_addr == abort_page[5:0]) begin
        abort = 1'b1; aborted = 1'b1; post = 3;
      end
      if (restart_at >= 0 && we && n_writes == restart_at) begin
        start = 1'b1; start_offset = ~off;
      end
      if (!pend && sent < 8 && (cyc % period) == 0) pend = 1'b1;
      in_valid = pend;
      in_data  = pend ? ((sent == 0) ? w0 : wr) : 16'h0;
      #1;
      if (in_valid && in_ready) begin sent++; pend = 1'b0; end
      @(posedge write_clk);
      #1;
      cyc++;
    end
    if (cyc >= 3000) timed_out = 1'b1;
    in_valid = 1'b0; abort = 1'b0; start = 1'b0; start_offset = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_tests++; if (lut_in_bank0 !== 1'b0) begin n_fail++; $display("FAIL reset_bank0: got %b expected 0", lut_in_bank0); end
    n_tests++; if (lut_in_bank1 !== 1'b0) begin n_fail++; $display("FAIL reset_bank1: got %b expected 0", lut_in_bank1); end
    n_tests++; if (page_write_addr !== 6'd0) begin n_fail++; $display("FAIL reset_page: got %0d expected 0", page_write_addr); end
    n_tests++; if (write_addr_offset !== 1'b0) begin n_fail++; $display("FAIL reset_offset: got %b expected 0", write_addr_offset); end
    n_tests++; if (we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", we); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    rst = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++; if (busy !== 1'b1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL start_latency: got busy=%b ready=%b expected 1/1", busy, in_ready); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask

  task automatic test_full_load();
    int bad = 0;
    run_load(1'b0, 16'hAAAA, 16'hAAAA, 1, -1, -1);
    for (int p = 0; p < NPAGES; p++) if (wr_b0[p] !== 1'b0 || wr_b1[p] !== 1'b1) bad++;
    n_tests++; if (timed_out) begin n_fail++; $display("FAIL full_timeout: got timeout expected done"); end
    n_tests++; if (n_writes != 64) begin n_fail++; $display("FAIL full_writes: got %0d expected 64", n_writes); end
    n_tests++; if (order_err != 0) begin n_fail++; $display("FAIL full_order: got %0d errors expected 0", order_err); end
    n_tests++; if (off_err != 0) begin n_fail++; $display("FAIL full_offset: got %0d errors expected 0", off_err); end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL full_banks: got %0d bad pages expected 0", bad); end
    n_tests++; if (!saw_done || done_gap_err != 0) begin n_fail++; $display("FAIL full_done_timing: got done=%b gap_err=%0d expected 1/0", saw_done, done_gap_err); end
    n_tests++; if (busy_at_done != 0) begin n_fail++; $display("FAIL full_busy_at_done: got %0d expected 0", busy_at_done); end
    n_tests++; if (ready_in_done != 0) begin n_fail++; $display("FAIL full_ready_in_done: got %0d expected 0", ready_in_done); end
  endtask

  task automatic test_single_bit();
    int bad = 0;
    run_load(1'b1, 16'h0001, 16'h0000, 1, -1, -1);
    for (int p = 0; p < NPAGES; p++)
      if (wr_b0[p] !== ((p == 0) ? 1'b1 : 1'b0) || wr_b1[p] !== 1'b0) bad++;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL bit_banks: got %0d bad pages expected 0", bad); end
    n_tests++; if (off_err != 0 || n_writes != 64) begin n_fail++; $display("FAIL bit_offset1: got off_err=%0d writes=%0d expected 0/64", off_err, n_writes); end
    n_tests++; if (!saw_done || order_err != 0) begin n_fail++; $display("FAIL bit_done: got done=%b order_err=%0d expected 1/0", saw_done, order_err); end
  endtask

  task automatic test_throttled();
    int bad = 0;
    logic [1:0] pat;
    run_load(1'b0, 16'h1B1B, 16'h1B1B, 3, -1, -1);
    for (int p = 0; p < NPAGES; p++) begin
      case (p % 4)
        0: pat = 2'b11;
        1: pat = 2'b10;
        2: pat = 2'b01;
        default: pat = 2'b00;
      endcase
      if (wr_b1[p] !== pat[1] || wr_b0[p] !== pat[0]) bad++;
    end
    n_tests++; if (timed_out || n_writes != 64) begin n_fail++; $display("FAIL thr_writes: got %0d timeout=%b expected 64/0", n_writes, timed_out); end
    n_tests++; if (order_err != 0) begin n_fail++; $display("FAIL thr_order: got %0d errors expected 0", order_err); end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL thr_banks: got %0d bad pages expected 0", bad); end
    n_tests++; if (!saw_done || done_gap_err != 0) begin n_fail++; $display("FAIL thr_done: got done=%b gap_err=%0d expected 1/0", saw_done, done_gap_err); end
  endtask

  task automatic test_abort();
    int bad = 0;
    run_load(1'b0, 16'hAAAA, 16'hAAAA, 1, 20, -1);
    n_tests++; if (n_writes != 21) begin n_fail++; $display("FAIL abort_writes: got %0d expected 21", n_writes); end
    n_tests++; if (we_after_abort != 0) begin n_fail++; $display("FAIL abort_we_low: got %0d writes expected 0", we_after_abort); end
    n_tests++; if (busy_after_abort != 0) begin n_fail++; $display("FAIL abort_busy: got %0d busy cycles expected 0", busy_after_abort); end
    n_tests++; if (saw_done) begin n_fail++; $display("FAIL abort_no_done: got done=1 expected 0"); end
    run_load(1'b0, 16'hFFFF, 16'hFFFF, 1, -1, -1);
    for (int p = 0; p < NPAGES; p++) if (wr_b0[p] !== 1'b1 || wr_b1[p] !== 1'b1) bad++;
    n_tests++; if (order_err != 0 || n_writes != 64) begin n_fail++; $display("FAIL abort_restart: got order_err=%0d writes=%0d expected 0/64", order_err, n_writes); end
    n_tests++; if (bad != 0 || !saw_done) begin n_fail++; $display("FAIL abort_restart_data: got bad=%0d done=%b expected 0/1", bad, saw_done); end
  endtask

  task automatic test_start_ignored();
    run_load(1'b0, 16'hAAAA, 16'hAAAA, 1, -1, 30);
    n_tests++; if (off_err != 0) begin n_fail++; $display("FAIL restart_offset: got %0d errors expected 0", off_err); end
    n_tests++; if (n_writes != 64 || order_err != 0) begin n_fail++; $display("FAIL restart_writes: got %0d order_err=%0d expected 64/0", n_writes, order_err); end
    n_tests++; if (!saw_done) begin n_fail++; $display("FAIL restart_done: got 0 expected 1"); end
  endtask

  task automatic test_reset_midload();
    int k = 0;
    start = 1'b1; start_offset = 1'b1;
    tick();
    start = 1'b0; start_offset = 1'b0;
    in_valid = 1'b1; in_data = 16'hFFFF;
    while (k < 40 && !(we && page_write_addr >= 6'd3)) begin tick(); k++; end
    n_tests++; if (!(we === 1'b1 && write_addr_offset === 1'b1 && lut_in_bank0 === 1'b1)) begin n_fail++; $display("FAIL rst_mid_setup: got we=%b off=%b b0=%b expected 1/1/1", we, write_addr_offset, lut_in_bank0); end
    rst = 1'b1;
    tick();
    n_tests++; if ({we, busy, done, in_ready} !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_ctrl: got we/busy/done/ready=%b expected 0000", {we, busy, done, in_ready}); end
    n_tests++; if ({lut_in_bank0, lut_in_bank1, write_addr_offset} !== 3'b000 || page_write_addr !== 6'd0) begin n_fail++; $display("FAIL rst_mid_data: got b0/b1/off=%b page=%0d expected 000/0", {lut_in_bank0, lut_in_bank1, write_addr_offset}, page_write_addr); end
    rst = 1'b0;
    tick(); tick();
    n_tests++; if (busy !== 1'b0 || in_ready !== 1'b0 || we !== 1'b0) begin n_fail++; $display("FAIL rst_mid_idle: got busy=%b ready=%b we=%b expected 0/0/0", busy, in_ready, we); end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_single_bit();
    test_throttled();
    test_abort();
    test_start_ignored();
    test_reset_midload();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
